// File: rtl/enc_pwm_pkg.sv
// rtl/enc_pwm_pkg.sv - shared step encoding, width helpers and debounce counter sizing
package enc_pwm_pkg;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DN   = 2'd2
    } step_t;

    localparam int DEBOUNCE_CYC_DEF = 4;
    localparam int DEBOUNCE_CNT_W   = $clog2(DEBOUNCE_CYC_DEF + 1);

    // Total packed width of a bank of level registers.
    function automatic int level_w(input int channels, input int width);
        return channels * width;
    endfunction

    function automatic int debounce_cnt_w(input int cyc);
        return $clog2(cyc + 1);
    endfunction

endpackage

// File: rtl/enc_channel.sv
// rtl/enc_channel.sv - one encoder channel: sync, debounce, quadrature decode, level register, PWM compare
module enc_channel
    import enc_pwm_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             wrap_mode,
    input  logic             load_hit,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] pcnt,
    output logic [WIDTH-1:0] level,
    output logic             pwm_out
);

    localparam int               CNT_W    = debounce_cnt_w(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [WIDTH-1:0] LVL_MAX  = '1;

    // Index 0 is phase A, index 1 is phase B.
    logic [1:0]       raw;
    logic [1:0]       s1;
    logic [1:0]       s2;
    logic [1:0]       stable;
    logic [CNT_W-1:0] cnt [2];
    logic             stable_a_d;
    step_t            step;

    logic [level_w(1, WIDTH)-1:0] active_lvl;

    assign raw = {enc_b, enc_a};

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            s1     <= '0;
            s2     <= '0;
            stable <= '0;
            for (int p = 0; p < 2; p++) begin
                cnt[p] <= '0;
            end
        end else begin
            s1 <= raw;
            s2 <= s1;
            for (int p = 0; p < 2; p++) begin
                if (s2[p] == stable[p]) begin
                    cnt[p] <= '0;
                end else if (cnt[p] == CNT_LAST) begin
                    stable[p] <= s2[p];
                    cnt[p]    <= '0;
                end else begin
                    cnt[p] <= cnt[p] + 1'b1;
                end
            end
        end
    end

    // Only the rising edge of A counts, giving one step per detent.
    always_comb begin
        step = STEP_NONE;
        if (stable[0] && !stable_a_d) begin
            step = stable[1] ? STEP_DN : STEP_UP;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            stable_a_d <= 1'b0;
            level      <= '0;
        end else begin
            stable_a_d <= stable[0];
            if (load_hit) begin
                level <= load_value;
            end else begin
                case (step)
                    STEP_UP: begin
                        if (level == LVL_MAX) begin
                            level <= wrap_mode ? '0 : level;
                        end else begin
                            level <= level + 1'b1;
                        end
                    end
                    STEP_DN: begin
                        if (level == '0) begin
                            level <= wrap_mode ? LVL_MAX : level;
                        end else begin
                            level <= level - 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Duty is latched on the last count of a period so each period is glitch-free.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            active_lvl <= '0;
            pwm_out    <= 1'b0;
        end else begin
            if (pcnt == LVL_MAX) begin
                active_lvl <= level;
            end
            pwm_out <= (pcnt < active_lvl);
        end
    end

endmodule

// File: rtl/enc_pwm_mixer.sv
// rtl/enc_pwm_mixer.sv - multi-channel encoder-to-PWM mixer top: shared period counter, load decode, level packing
module enc_pwm_mixer
    import enc_pwm_pkg::*;
#(
    parameter int CHANNELS     = 3,
    parameter int WIDTH        = 8,
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic                                   clk,
    input  logic                                   resetb,
    input  logic [CHANNELS-1:0]                    enc_a,
    input  logic [CHANNELS-1:0]                    enc_b,
    input  logic                                   wrap_mode,
    input  logic                                   load_en,
    input  logic [2:0]                             load_ch,
    input  logic [WIDTH-1:0]                       load_value,
    output logic [level_w(CHANNELS, WIDTH)-1:0]    level_out,
    output logic [CHANNELS-1:0]                    pwm_out
);

    logic [WIDTH-1:0]    pcnt;
    logic [CHANNELS-1:0] load_hit;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    // Out-of-range channel indices match no channel, so the load is dropped.
    always_comb begin
        load_hit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            load_hit[i] = load_en && (load_ch == 3'(i));
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        enc_channel #(
            .WIDTH        (WIDTH),
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_ch (
            .clk        (clk),
            .resetb     (resetb),
            .enc_a      (enc_a[g]),
            .enc_b      (enc_b[g]),
            .wrap_mode  (wrap_mode),
            .load_hit   (load_hit[g]),
            .load_value (load_value),
            .pcnt       (pcnt),
            .level      (level_out[g*WIDTH +: WIDTH]),
            .pwm_out    (pwm_out[g])
        );
    end

endmodule

// File: tb/tb_enc_pwm_mixer.sv
// tb/tb_enc_pwm_mixer.sv - scoreboard bench for enc_pwm_mixer with directed encoder, load and PWM vectors
module tb_enc_pwm_mixer;

    localparam int CH = 3;
    localparam int W  = 8;
    localparam int DB = 4;

    logic        clk        = 1'b0;
    logic        resetb     = 1'b0;
    logic [2:0]  enc_a      = '0;
    logic [2:0]  enc_b      = '0;
    logic        wrap_mode  = 1'b0;
    logic        load_en    = 1'b0;
    logic [2:0]  load_ch    = '0;
    logic [7:0]  load_value = '0;
    logic [23:0] level_out;
    logic [2:0]  pwm_out;

    enc_pwm_mixer #(
        .CHANNELS     (CH),
        .WIDTH        (W),
        .DEBOUNCE_CYC (DB)
    ) dut (
        .clk        (clk),
        .resetb     (resetb),
        .enc_a      (enc_a),
        .enc_b      (enc_b),
        .wrap_mode  (wrap_mode),
        .load_en    (load_en),
        .load_ch    (load_ch),
        .load_value (load_value),
        .level_out  (level_out),
        .pwm_out    (pwm_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [23:0] lvl;
    } lvl_exp_t;

    typedef struct {
        int period;
        int ch;
        int cnt;
    } pwm_exp_t;

    lvl_exp_t   lvl_q[$];
    pwm_exp_t   pwm_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc;
    logic [7:0] exp_lvl [3];

    // Clock edges since reset release; edge n leaves the period counter at n mod 256.
    always @(posedge clk or negedge resetb) begin
        if (!resetb) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endfunction

    logic [23:0] prev_lvl;
    int          hc [3];
    lvl_exp_t    me;
    pwm_exp_t    mp;

    always @(negedge clk) begin
        if (!resetb) begin
            prev_lvl = level_out;
            for (int i = 0; i < 3; i++) hc[i] = 0;
        end else begin
            if (level_out !== prev_lvl) begin
                if (lvl_q.size() == 0) begin
                    chk("unexpected_level_change", level_out, prev_lvl);
                end else begin
                    me = lvl_q.pop_front();
                    chk("level_value", level_out, me.lvl);
                    chk("level_cycle", cyc, me.cyc);
                end
            end
            prev_lvl = level_out;
            for (int i = 0; i < 3; i++) if (pwm_out[i]) hc[i]++;
            if (cyc != 0 && (cyc % 256) == 0) begin
                while (pwm_q.size() > 0 && pwm_q[0].period <= cyc / 256 - 1) begin
                    mp = pwm_q.pop_front();
                    if (mp.period < cyc / 256 - 1)
                        chk("pwm_period_missed", mp.period, cyc / 256 - 1);
                    else
                        chk($sformatf("pwm_high_ch%0d_p%0d", mp.ch, mp.period), hc[mp.ch], mp.cnt);
                end
                for (int i = 0; i < 3; i++) hc[i] = 0;
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_lvl(input int ch, input logic [7:0] v, input int at);
        lvl_exp_t e;
        exp_lvl[ch] = v;
        e.cyc = at;
        for (int i = 0; i < 3; i++) e.lvl[i*8 +: 8] = exp_lvl[i];
        lvl_q.push_back(e);
    endtask

    task automatic expect_pwm(input int period, input int ch, input int cnt);
        pwm_exp_t p;
        p.period = period;
        p.ch     = ch;
        p.cnt    = cnt;
        pwm_q.push_back(p);
    endtask

    // Entered and left on a falling edge.
    task automatic detent(input int ch, input logic dn, input logic [7:0] v, input bit chg);
        enc_b[ch] = dn;
        wait_cyc(3);
        enc_a[ch] = 1'b1;
        if (chg) expect_lvl(ch, v, cyc + 7);
        wait_cyc(10);
        enc_a[ch] = 1'b0;
        wait_cyc(10);
        enc_b[ch] = 1'b0;
        wait_cyc(2);
    endtask

    task automatic load(input int ch, input logic [7:0] v, input bit chg);
        load_en    = 1'b1;
        load_ch    = 3'(ch);
        load_value = v;
        if (chg) expect_lvl(ch, v, cyc + 1);
        @(negedge clk);
        load_en = 1'b0;
    endtask

    int q;

    initial begin
        for (int i = 0; i < 3; i++) exp_lvl[i] = 8'd0;

        resetb = 1'b0;
        repeat (8) begin
            @(negedge clk);
            enc_a      = 3'($urandom);
            enc_b      = 3'($urandom);
            load_en    = 1'($urandom);
            load_ch    = 3'($urandom);
            load_value = 8'($urandom);
        end
        chk("reset_level", level_out, 24'h0);
        chk("reset_pwm", pwm_out, 3'b000);
        @(negedge clk);
        enc_a   = '0;
        enc_b   = '0;
        load_en = 1'b0;
        @(negedge clk);
        resetb = 1'b1;
        wait_cyc(12);
        chk("post_release_level", level_out, 24'h0);
        chk("post_release_pwm", pwm_out, 3'b000);

        detent(0, 1'b0, 8'd1, 1'b1);
        detent(0, 1'b0, 8'd2, 1'b1);
        detent(0, 1'b0, 8'd3, 1'b1);
        detent(0, 1'b0, 8'd4, 1'b1);
        detent(0, 1'b0, 8'd5, 1'b1);

        enc_a[1] = 1'b1;
        wait_cyc(3);
        enc_a[1] = 1'b0;
        wait_cyc(15);
        enc_a[1] = 1'b1;
        expect_lvl(1, 8'd1, cyc + 7);
        wait_cyc(4);
        enc_a[1] = 1'b0;
        wait_cyc(15);

        wrap_mode = 1'b0;
        detent(2, 1'b1, 8'd0, 1'b0);
        load(2, 8'd255, 1'b1);
        wait_cyc(3);
        detent(2, 1'b0, 8'd255, 1'b0);
        wrap_mode = 1'b1;
        wait_cyc(2);
        detent(2, 1'b0, 8'd0, 1'b1);
        detent(2, 1'b1, 8'd255, 1'b1);

        enc_a[0] = 1'b1;
        wait_cyc(6);
        load(0, 8'h80, 1'b1);
        wait_cyc(10);
        enc_a[0] = 1'b0;
        wait_cyc(10);

        load(5, 8'h33, 1'b0);
        wait_cyc(10);
        wrap_mode = 1'b0;

        load(0, 8'd0, 1'b1);
        wait_cyc(300);
        while ((cyc % 256) != 128) @(negedge clk);
        q = cyc / 256;
        expect_pwm(q, 0, 0);
        expect_pwm(q, 1, 1);
        expect_pwm(q, 2, 255);
        load(0, 8'd64, 1'b1);
        load(1, 8'd0, 1'b1);
        expect_pwm(q + 1, 0, 64);
        expect_pwm(q + 1, 1, 0);
        expect_pwm(q + 1, 2, 255);
        wait_cyc(400);

        @(negedge clk);
        #2 resetb = 1'b0;
        #1;
        chk("midrun_reset_level", level_out, 24'h0);
        chk("midrun_reset_pwm", pwm_out, 3'b000);
        for (int i = 0; i < 3; i++) exp_lvl[i] = 8'd0;
        @(negedge clk);
        @(negedge clk);
        resetb = 1'b1;
        wait_cyc(5);
        detent(0, 1'b0, 8'd1, 1'b1);

        wait_cyc(20);
        chk("level_queue_drained", lvl_q.size(), 0);
        chk("pwm_queue_drained", pwm_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
